// File: rtl/demorgan_chk_pkg.sv
// Shared types and sizing helpers for the De Morgan sweep checker.
package demorgan_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } chkState_t;

    function automatic int idxWidth(input int w);
        return 2 * w;
    endfunction

    function automatic int vecCount(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/demorgan_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle wait before each sample.
module demorgan_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps every {a,b} vector into a De Morgan gate pair and counts output mismatches.
// Define DEMORGAN_CHK_CAPTURE_EN to record the first mismatching vector on fail_vec.
module demorgan_sweep_checker
    import demorgan_chk_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   stim_a,
    output logic [WIDTH-1:0]   stim_b,
    input  logic [WIDTH-1:0]   lhs_in,
    input  logic [WIDTH-1:0]   rhs_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH-1:0] fail_vec
);

    localparam int IDX_W = idxWidth(WIDTH);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    chkState_t state, nextState;

    logic [IDX_W-1:0] idx;
    logic [ERR_W-1:0] errCount;
    logic [ERR_W-1:0] errNext;
    logic busyR, doneR, passR;
    logic startSweep, loadTimer, decTimer, sampleNow;
    logic lastVec, mismatch, timerZero;

    demorgan_settle_timer #(
        .CNT_W(8)
    ) settleTimer (
        .clk    (clk),
        .reset  (reset),
        .load   (loadTimer),
        .loadVal(SETTLE_LOAD),
        .dec    (decTimer),
        .zero   (timerZero)
    );

    assign lastVec  = (idx == '1);
    assign mismatch = |(lhs_in ^ rhs_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        startSweep = 1'b0;
        loadTimer  = 1'b0;
        decTimer   = 1'b0;
        sampleNow  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nextState  = ST_SETTLE;
                    startSweep = 1'b1;
                    loadTimer  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timerZero) begin
                    nextState = ST_SAMPLE;
                end else begin
                    decTimer = 1'b1;
                end
            end
            ST_SAMPLE: begin
                sampleNow = 1'b1;
                if (lastVec) begin
                    nextState = ST_DONE;
                end else begin
                    nextState = ST_SETTLE;
                    loadTimer = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // One count per mismatching vector, pinned at all-ones once saturated.
    always_comb begin
        errNext = errCount;
        if (sampleNow && mismatch && (errCount != '1)) begin
            errNext = errCount + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            errCount <= '0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            passR    <= 1'b0;
        end else if (startSweep) begin
            idx      <= '0;
            errCount <= '0;
            busyR    <= 1'b1;
            doneR    <= 1'b0;
            passR    <= 1'b0;
        end else if (sampleNow) begin
            errCount <= errNext;
            if (lastVec) begin
                busyR <= 1'b0;
                doneR <= 1'b1;
                passR <= (errNext == '0);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef DEMORGAN_CHK_CAPTURE_EN
    logic [2*WIDTH-1:0] failVec;

    // A zero error count at a mismatching sample marks the first failure of this sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            failVec <= '0;
        end else if (startSweep) begin
            failVec <= '0;
        end else if (sampleNow && mismatch && (errCount == '0)) begin
            failVec <= {stim_a, stim_b};
        end
    end

    assign fail_vec = failVec;
`else
    assign fail_vec = '0;
`endif

    assign stim_a    = idx[IDX_W-1:WIDTH];
    assign stim_b    = idx[WIDTH-1:0];
    assign busy      = busyR;
    assign done      = doneR;
    assign pass      = passR;
    assign err_count = errCount;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: three configurations run against a sweep-timing reference model.
module tb_demorgan_sweep_checker;
    import demorgan_chk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] start;
    int total = 0;
    int bad   = 0;

    logic       mode0;
    logic [1:0] faultMask1 [16];

    // Instance 0: WIDTH=1 SETTLE=2 ERR_W=8, correct or faulty pair selected by mode0
    logic       a0, b0, lhs0, rhs0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] fv0;
    assign lhs0 = ~(a0 | b0);
    assign rhs0 = mode0 ? (~a0 | ~b0) : (~a0 & ~b0);

    demorgan_sweep_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(8)) u0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .stim_a(a0), .stim_b(b0), .lhs_in(lhs0), .rhs_in(rhs0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
    );

    // Instance 1: WIDTH=2 SETTLE=1 ERR_W=8, correct pair with injectable per-vector faults
    logic [1:0] a1, b1, lhs1, rhs1;
    logic       busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] fv1;
    assign lhs1 = ~(a1 | b1);
    assign rhs1 = (~a1 & ~b1) ^ faultMask1[{a1, b1}];

    demorgan_sweep_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(8)) u1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .stim_a(a1), .stim_b(b1), .lhs_in(lhs1), .rhs_in(rhs1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    // Instance 2: WIDTH=1 SETTLE=2 ERR_W=1, rhs always the inverse of lhs
    logic       a2, b2, lhs2, rhs2, busy2, done2, pass2;
    logic [0:0] err2;
    logic [1:0] fv2;
    assign lhs2 = ~(a2 | b2);
    assign rhs2 = ~lhs2;

    demorgan_sweep_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(1)) u2 (
        .clk(clk), .reset(reset), .start(start[2]),
        .stim_a(a2), .stim_b(b2), .lhs_in(lhs2), .rhs_in(rhs2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fv2)
    );

    logic [31:0] obsA [3], obsB [3], obsErr [3], obsFv [3];
    logic        obsBusy [3], obsDone [3], obsPass [3];

    always_comb begin
        obsA[0] = 32'(a0);   obsB[0] = 32'(b0);   obsErr[0] = 32'(err0); obsFv[0] = 32'(fv0);
        obsA[1] = 32'(a1);   obsB[1] = 32'(b1);   obsErr[1] = 32'(err1); obsFv[1] = 32'(fv1);
        obsA[2] = 32'(a2);   obsB[2] = 32'(b2);   obsErr[2] = 32'(err2); obsFv[2] = 32'(fv2);
        obsBusy[0] = busy0;  obsDone[0] = done0;  obsPass[0] = pass0;
        obsBusy[1] = busy1;  obsDone[1] = done1;  obsPass[1] = pass1;
        obsBusy[2] = busy2;  obsDone[2] = done2;  obsPass[2] = pass2;
    end

    function automatic int cfgW(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int cfgS(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cfgE(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int span(input int i);
        return vecCount(cfgW(i)) * (cfgS(i) + 1);
    endfunction

    // Whether vector v of instance i produces differing outputs from its gate pair
    function automatic bit mm(input int i, input int v);
        if (i == 0) begin
            return mode0 ? (((v >> 1) & 1) != (v & 1)) : 1'b0;
        end else if (i == 1) begin
            return faultMask1[v] != 2'b00;
        end
        return 1'b1;
    endfunction

    // Reference state: edges elapsed since the accepted start, plus accumulated errors
    int run [3], k [3], mErr [3], mFirst [3], mHasFirst [3];

    function automatic bit mBusy(input int i);
        return (run[i] != 0) && (k[i] < span(i));
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d at t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic waitDone(input int i, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (obsDone[i] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", i, 32'(obsDone[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; k[i] = 0; mErr[i] = 0; mFirst[i] = 0; mHasFirst[i] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    run[i] = 0; k[i] = 0; mErr[i] = 0; mFirst[i] = 0; mHasFirst[i] = 0;
                end else if (!mBusy(i) && start[i]) begin
                    run[i] = 1; k[i] = 0; mErr[i] = 0; mFirst[i] = 0; mHasFirst[i] = 0;
                end else if (mBusy(i)) begin
                    if ((k[i] + 1) % (cfgS(i) + 1) == 0) begin
                        int v;
                        v = (k[i] + 1) / (cfgS(i) + 1) - 1;
                        if (mm(i, v)) begin
                            if (mHasFirst[i] == 0) begin
                                mFirst[i] = v;
                                mHasFirst[i] = 1;
                            end
                            if (mErr[i] < (1 << cfgE(i)) - 1) mErr[i] = mErr[i] + 1;
                        end
                    end
                    k[i] = k[i] + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int v, ea, eb, eErr, eFv, eBusy, eDone, ePass;
                ea = 0; eb = 0; eErr = 0; eFv = 0; eBusy = 0; eDone = 0; ePass = 0;
                if (run[i] != 0) begin
                    v = k[i] / (cfgS(i) + 1);
                    if (v > vecCount(cfgW(i)) - 1) v = vecCount(cfgW(i)) - 1;
                    ea = v >> cfgW(i);
                    eb = v & ((1 << cfgW(i)) - 1);
                    eBusy = (k[i] < span(i)) ? 1 : 0;
                    eDone = 1 - eBusy;
                    eErr = mErr[i];
                    ePass = (eDone == 1 && mErr[i] == 0) ? 1 : 0;
`ifdef DEMORGAN_CHK_CAPTURE_EN
                    eFv = (mHasFirst[i] != 0) ? mFirst[i] : 0;
`endif
                end
                check("stim_a", i, obsA[i], 32'(ea));
                check("stim_b", i, obsB[i], 32'(eb));
                check("busy", i, 32'(obsBusy[i]), 32'(eBusy));
                check("done", i, 32'(obsDone[i]), 32'(eDone));
                check("pass", i, 32'(obsPass[i]), 32'(ePass));
                check("err_count", i, obsErr[i], 32'(eErr));
                check("fail_vec", i, obsFv[i], 32'(eFv));
            end
        end
    end

    initial begin
        logic [31:0] fvWant;
`ifdef DEMORGAN_CHK_CAPTURE_EN
        fvWant = 32'd1;
`else
        fvWant = 32'd0;
`endif
        reset = 1'b1;
        start = 3'b000;
        mode0 = 1'b0;
        for (int v = 0; v < 16; v++) faultMask1[v] = 2'b00;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 0, 32'(busy0), 32'd0);
        check("rst_done", 0, 32'(done0), 32'd0);
        check("rst_err", 0, 32'(err0), 32'd0);

        // Clean sweep on all three, with start pulses on instance 0 at cycles 3 and 7
        @(posedge clk); #2 start = 3'b111;
        @(posedge clk); #2 start = 3'b000;
        repeat (2) @(posedge clk);
        #2 start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("done_before_12", 0, 32'(done0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_at_12", 0, 32'(done0), 32'd1);
        check("pass_clean", 0, 32'(pass0), 32'd1);
        check("err_clean", 0, 32'(err0), 32'd0);
        check("err_sat_w1", 2, 32'(err2), 32'd1);
        check("pass_sat_w1", 2, 32'(pass2), 32'd0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("w2_done_before_32", 1, 32'(done1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("w2_done_at_32", 1, 32'(done1), 32'd1);
        check("w2_pass", 1, 32'(pass1), 32'd1);

        // Faulty pair, restarted from DONE
        @(posedge clk); #2 mode0 = 1'b1; start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        @(negedge clk);
        check("restart_clears_done", 0, 32'(done0), 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("faulty_done", 0, 32'(done0), 32'd1);
        check("faulty_err", 0, 32'(err0), 32'd2);
        check("faulty_pass", 0, 32'(pass0), 32'd0);
        check("faulty_fail_vec", 0, 32'(fv0), fvWant);

        // Reset at cycle 5 of a sweep, then a full clean sweep
        @(posedge clk); #2 mode0 = 1'b0; start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 0, 32'(busy0), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 0, 32'(busy0), 32'd0);
        check("async_stim_b", 0, 32'(b0), 32'd0);
        check("async_done", 0, 32'(done0), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        waitDone(0, 20);
        check("post_reset_pass", 0, 32'(pass0), 32'd1);

        // Randomized fault patterns, start timing, spurious starts and occasional resets
        for (int it = 0; it < 30; it++) begin
            @(posedge clk);
            #2;
            mode0 = 1'($urandom_range(0, 1));
            for (int v = 0; v < 16; v++)
                faultMask1[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            start = 3'($urandom_range(0, 7));
            @(posedge clk); #2 start = 3'b000;
            for (int c = $urandom_range(5, 40); c > 0; c--) begin
                @(posedge clk);
                #2 start = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            end
            start = 3'b000;
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #3 reset = 1'b1;
                @(posedge clk); #2 reset = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
Name: demorgan_sweep_checker

Overview:
- Synthesizable self-checking stimulus/response engine for the De Morgan gate pairs.
- Drives every A,B combination into a gate-level DUT pair and captures the two equivalent-form outputs, e.g. ~(A+B) vs ~A·~B.
- Counts mismatches and reports pass/fail. It is the hardware counterpart of the truth-table benches, so equivalence checks can run on-chip or in long regressions without $display inspection.

Parameters:
- WIDTH, 1: bits per operand (stim_a, stim_b); vector index is 2*WIDTH bits.
- SETTLE, 2: cycles waited after driving a vector before sampling; legal range 1..255.
- ERR_W, 8: width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- stim_a  out  WIDTH  operand A driven to the DUT pair.
- stim_b  out  WIDTH  operand B driven to the DUT pair.
- lhs_in  in  WIDTH  output of DUT form 1.
- rhs_in  in  WIDTH  output of DUT form 2.
- busy  out  1  high from the cycle after start until DONE is entered.
- done  out  1  high while in DONE.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating at all-ones.
- fail_vec  out  2*WIDTH  {a,b} of the first mismatching vector (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=IDLE; stim_a=stim_b=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; vector index=0; settle counter=0. Reset asserted mid-sweep aborts immediately with the same values and no partial report.
- IDLE: start=1 -> SETTLE. Same edge: index=0, stim={0,0}, err_count=0, fail_vec=0, settle counter=SETTLE-1, busy=1.
- SETTLE: stim_a/stim_b held constant at index[2W-1:W]/index[W-1:0]. Counter decrements each cycle; at 0 -> SAMPLE.
- SAMPLE (1 cycle): compare lhs_in vs rhs_in bitwise. Any differing bit counts as one mismatch: err_count+1 unless already all-ones.
  - If index==all-ones -> DONE.
  - Else index+1, new stim driven on the same edge, counter=SETTLE-1 -> SETTLE.
- Latency per vector: SETTLE+1 cycles. Full sweep from start edge to done=1: 2^(2*WIDTH)*(SETTLE+1) cycles. WIDTH=1, SETTLE=2: 12 cycles.
- DONE: busy=0, done=1, pass=(err_count==0); outputs and stim held. start=1 -> restarts exactly as from IDLE, with done cleared on that edge.
- start while busy: ignored, no restart.
- Index wrap: none; all-ones is terminal. Index width exactly 2*WIDTH, no extra bit.
- Mismatch on the final vector: counted before done asserts.
- Ones-count saturation: with err_count all-ones, further mismatches leave it unchanged and pass stays 0.

Optional Feature:
- Macro DEMORGAN_CHK_CAPTURE_EN.
- Defined: fail_vec loads {stim_a,stim_b} at the first mismatching SAMPLE of a sweep and holds until the next start or reset.
- Undefined: no capture register; fail_vec is tied to 0. All other behaviour is identical.

Decomposition:
- Package demorgan_chk_pkg: state encoding typedef (IDLE, SETTLE, SAMPLE, DONE as 2-bit enum) and localparam helpers (vector count 2^(2W), index width).
- One sub-module: demorgan_settle_timer. Loadable down-counter with a zero flag, reused for SETTLE timing. The comparator and counters stay inline.

Test Plan:
- Correct pair (lhs=~(a|b), rhs=~a&~b), WIDTH=1, SETTLE=2, start pulse -> stim sequence 00,01,10,11 with each value held 3 cycles; done=1 at cycle 12; pass=1; err_count=0.
- Faulty pair (rhs=~a|~b vs lhs=~(a|b)) -> mismatches at 01 and 10; err_count=2; pass=0. fail_vec=2'b01 with the macro defined; 0 without.
- Reset asserted at cycle 5 of a sweep -> all outputs 0 asynchronously, state IDLE. A later start runs a full clean sweep.
- start pulsed at cycles 3 and 7 during busy -> ignored; done still at cycle 12. start in DONE -> done clears next edge and the sweep repeats.
- ERR_W=1, rhs forced to ~lhs -> err_count saturates at 1 after the first vector and stays 1; pass=0.
- WIDTH=2, SETTLE=1, correct pair -> 16 vectors, done at cycle 32, pass=1.
